// File: rtl/game_pkg.sv
// Shared definitions for the stage loader: grid geometry, cell codes and
// the loader state encoding.
package game_pkg;

    localparam int STAGE_BITS     = 2;
    localparam int GRID_COL_BITS  = 4;
    localparam int GRID_ROW_BITS  = 4;
    localparam int CELL_CODE_BITS = 3;

    localparam logic [CELL_CODE_BITS-1:0] CELL_FLOOR       = 3'd0;
    localparam logic [CELL_CODE_BITS-1:0] CELL_WALL        = 3'd1;
    localparam logic [CELL_CODE_BITS-1:0] CELL_GOAL        = 3'd2;
    localparam logic [CELL_CODE_BITS-1:0] CELL_BOX         = 3'd3;
    localparam logic [CELL_CODE_BITS-1:0] CELL_BOX_GOAL    = 3'd4;
    localparam logic [CELL_CODE_BITS-1:0] CELL_PLAYER      = 3'd5;
    localparam logic [CELL_CODE_BITS-1:0] CELL_PLAYER_GOAL = 3'd6;
    localparam logic [CELL_CODE_BITS-1:0] CELL_RSVD        = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_COPY  = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

    // Reserved code is scrubbed to floor so the playfield never holds it.
    function automatic logic [CELL_CODE_BITS-1:0] map_cell(input logic [CELL_CODE_BITS-1:0] code);
        return (code == CELL_RSVD) ? CELL_FLOOR : code;
    endfunction

endpackage

// File: rtl/loader_cell_stats.sv
// Running statistics over the cells being written: player count (saturating
// at 2), index of the last player cell, and number of loose boxes.
// The *_o outputs are the next-state values, so the owner can capture totals
// that already include the cell being written in the current cycle.
module loader_cell_stats #(
    parameter int IDX_W     = 8,
    parameter int CELL_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 wr_vld_i,
    input  logic [CELL_BITS-1:0] code_i,
    input  logic [IDX_W-1:0]     idx_i,
    output logic [1:0]           player_cnt_o,
    output logic [IDX_W-1:0]     player_idx_o,
    output logic [IDX_W:0]       box_cnt_o
);
    import game_pkg::*;

    logic [1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   box_q, box_d;
    logic             is_player;

    assign is_player = (code_i == CELL_PLAYER) || (code_i == CELL_PLAYER_GOAL);

    // Next-state: clear on a new load, otherwise fold in the current write.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        box_d = box_q;
        if (clear_i) begin
            cnt_d = '0;
            idx_d = '0;
            box_d = '0;
        end else if (wr_vld_i) begin
            if (is_player) begin
                idx_d = idx_i;
                if (cnt_q != 2'd2) cnt_d = cnt_q + 2'd1;
            end
            if (code_i == CELL_BOX) box_d = box_q + (IDX_W+1)'(1);
        end
    end

    // Statistic registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            box_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            box_q <= box_d;
        end
    end

    assign player_cnt_o = cnt_d;
    assign player_idx_o = idx_d;
    assign box_cnt_o    = box_d;

endmodule

// File: rtl/game_stage_loader.sv
// Copies one stage's map from the level ROM into the playfield RAM, one cell
// per cycle, and reports the player start position, loose box count and
// whether the map has exactly one player.
module game_stage_loader #(
    parameter int STAGE_BITS = game_pkg::STAGE_BITS,
    parameter int COL_BITS   = game_pkg::GRID_COL_BITS,
    parameter int ROW_BITS   = game_pkg::GRID_ROW_BITS,
    parameter int CELL_BITS  = game_pkg::CELL_CODE_BITS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [STAGE_BITS-1:0]                stage,
    input  logic                                 load_req,
    output logic [STAGE_BITS+COL_BITS+ROW_BITS-1:0] rom_addr,
    input  logic [CELL_BITS-1:0]                 rom_data,
    output logic                                 ram_we,
    output logic [COL_BITS+ROW_BITS-1:0]         ram_addr,
    output logic [CELL_BITS-1:0]                 ram_wdata,
    output logic                                 busy,
    output logic                                 done,
    output logic [COL_BITS-1:0]                  player_x,
    output logic [ROW_BITS-1:0]                  player_y,
    output logic [COL_BITS+ROW_BITS:0]           box_count,
    output logic                                 error
);
    import game_pkg::*;

    localparam int IDX_W  = COL_BITS + ROW_BITS;
    localparam int ADDR_W = STAGE_BITS + IDX_W;
    localparam int CNT_W  = IDX_W + 1;

    loader_state_e         state_q;
    logic [STAGE_BITS-1:0] stage_q;
    logic [IDX_W-1:0]      cell_q;     // next cell to fetch from ROM
    logic [IDX_W-1:0]      cell_nxt;
    logic [ADDR_W-1:0]     rom_addr_q;
    logic                  ram_we_q;
    logic [IDX_W-1:0]      ram_addr_q;
    logic                  busy_q;
    logic                  done_q;
    logic [COL_BITS-1:0]   px_q;
    logic [ROW_BITS-1:0]   py_q;
    logic [CNT_W-1:0]      box_q;
    logic                  err_q;

    logic                  accept;
    logic                  last_wr;
    logic [1:0]            st_cnt;
    logic [IDX_W-1:0]      st_idx;
    logic [CNT_W-1:0]      st_box;

    // A request is only honoured when no copy is in flight.
    assign accept   = load_req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign cell_nxt = cell_q + IDX_W'(1);
    assign last_wr  = ram_we_q && (ram_addr_q == '1);

    loader_cell_stats #(
        .IDX_W     (IDX_W),
        .CELL_BITS (CELL_BITS)
    ) u_stats (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (accept),
        .wr_vld_i     (ram_we_q),
        .code_i       (rom_data),
        .idx_i        (ram_addr_q),
        .player_cnt_o (st_cnt),
        .player_idx_o (st_idx),
        .box_cnt_o    (st_box)
    );

    // Loader FSM: PRIME issues the first ROM read, COPY writes one cell per
    // cycle while fetching the next, DONE publishes the captured results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            cell_q     <= '0;
            rom_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            box_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        stage_q    <= stage;
                        cell_q     <= '0;
                        rom_addr_q <= {stage, {IDX_W{1'b0}}};
                        busy_q     <= 1'b1;
                        state_q    <= ST_PRIME;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_PRIME: begin
                    ram_we_q   <= 1'b1;
                    ram_addr_q <= cell_q;
                    cell_q     <= cell_nxt;
                    rom_addr_q <= {stage_q, cell_nxt};
                    state_q    <= ST_COPY;
                end
                ST_COPY: begin
                    if (last_wr) begin
                        ram_we_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        px_q     <= st_idx[COL_BITS-1:0];
                        py_q     <= st_idx[IDX_W-1:COL_BITS];
                        box_q    <= st_box;
                        err_q    <= (st_cnt != 2'd1);
                        state_q  <= ST_DONE;
                    end else begin
                        ram_addr_q <= cell_q;
                        cell_q     <= cell_nxt;
                        rom_addr_q <= {stage_q, cell_nxt};
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rom_addr  = rom_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_we_q ? map_cell(rom_data) : '0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign player_x  = px_q;
    assign player_y  = py_q;
    assign box_count = box_q;
    assign error     = err_q;

endmodule

// File: tb/tb_game_stage_loader.sv
// Bench for game_stage_loader: synchronous ROM model, per-cycle comparison
// against a map-level reference, and directed loads with literal results.
module tb_game_stage_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] stage = 2'd0;
    logic       load_req = 1'b0;
    logic [9:0] rom_addr;
    logic [2:0] rom_data = 3'd0;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [2:0] ram_wdata;
    logic       busy, done;
    logic [3:0] player_x, player_y;
    logic [8:0] box_count;
    logic       error;

    logic [2:0] rom_mem [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Level ROM: one cycle read latency.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    game_stage_loader dut (
        .clk       (clk),
        .rst       (rst),
        .stage     (stage),
        .load_req  (load_req),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .done      (done),
        .player_x  (player_x),
        .player_y  (player_y),
        .box_count (box_count),
        .error     (error)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0] px;
        logic [3:0] py;
        logic [8:0] box;
        logic       err;
    } res_t;

    // Whole-map summary: last player cell, number of player cells, loose boxes.
    function automatic res_t eval_map(input logic [1:0] s);
        res_t       r;
        int         np;
        int         last;
        logic [2:0] c;
        r = '0; np = 0; last = 0;
        for (int i = 0; i < 256; i++) begin
            c = rom_mem[int'(s) * 256 + i];
            if (c == 3'd5 || c == 3'd6) begin np++; last = i; end
            if (c == 3'd3) r.box = r.box + 9'd1;
        end
        r.px  = 4'(last % 16);
        r.py  = 4'(last / 16);
        r.err = (np != 1);
        return r;
    endfunction

    // m_n = cycles since the accepting edge: 0 prime, 1..256 writes, 257 done.
    bit         m_active = 1'b0;
    int         m_n = 0;
    logic [1:0] m_stg = 2'd0;
    res_t       m_pend = '0;
    res_t       m_res = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_n      <= 0;
            m_res    <= '0;
        end else if (load_req && (!m_active || m_n == 257)) begin
            m_active <= 1'b1;
            m_n      <= 0;
            m_stg    <= stage;
            m_pend   <= eval_map(stage);
        end else if (m_active) begin
            if (m_n == 257) m_active <= 1'b0;
            else begin
                m_n <= m_n + 1;
                if (m_n == 256) m_res <= m_pend;
            end
        end
    end

    logic [2:0] exp_code;

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_ram_wdata", ram_wdata, 0);
            check("rst_rom_addr", rom_addr, 0);
            check("rst_pos", {player_y, player_x}, 0);
            check("rst_box", box_count, 0);
            check("rst_error", error, 0);
        end else begin
            check("busy", busy, m_active && m_n <= 256);
            check("done", done, m_active && m_n == 257);
            check("ram_we", ram_we, m_active && m_n >= 1 && m_n <= 256);
            if (m_active && m_n >= 1 && m_n <= 256) begin
                exp_code = rom_mem[int'(m_stg) * 256 + m_n - 1];
                check("ram_addr", ram_addr, m_n - 1);
                check("ram_wdata", ram_wdata, (exp_code == 3'd7) ? 3'd0 : exp_code);
            end
            if (m_active && m_n <= 255)
                check("rom_addr", rom_addr, int'(m_stg) * 256 + m_n);
            check("player_x", player_x, m_res.px);
            check("player_y", player_y, m_res.py);
            check("box_count", box_count, m_res.box);
            check("error", error, m_res.err);
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge of the expected done cycle.
    task automatic do_load(input logic [1:0] s, input int mid_at, output int ndone);
        int first_we;
        int done_at;
        first_we = -1; done_at = -1; ndone = 0;
        stage = s; load_req = 1'b1;
        for (int c = 1; c <= 258; c++) begin
            @(negedge clk);
            if (c == 1) load_req = 1'b0;
            if (ram_we && first_we < 0) first_we = c;
            if (done) begin ndone++; if (done_at < 0) done_at = c; end
            if (c == mid_at) begin stage = s ^ 2'd1; load_req = 1'b1; end
            else if (c == mid_at + 1) load_req = 1'b0;
        end
        check("first_we_latency", first_we, 2);
        check("done_latency", done_at, 258);
    endtask

    int nd;
    bit found;
    int r;

    initial begin
        // Stage 0: wall border, player at 0x23, three loose boxes, goals.
        for (int i = 0; i < 256; i++)
            rom_mem[i] = (i < 16 || i >= 240 || i % 16 == 0 || i % 16 == 15) ? 3'd1 : 3'd0;
        rom_mem[8'h23] = 3'd5;
        rom_mem[8'h34] = 3'd3; rom_mem[8'h45] = 3'd3; rom_mem[8'h56] = 3'd3;
        rom_mem[8'h67] = 3'd2; rom_mem[8'h78] = 3'd2; rom_mem[8'h9A] = 3'd4;
        // Stage 1: no player. Stages 2/3: mixed cells including reserved code.
        for (int i = 0; i < 256; i++) begin
            rom_mem[256 + i] = 3'($urandom_range(0, 4));
            r = $urandom_range(0, 5); rom_mem[512 + i] = (r == 5) ? 3'd7 : 3'(r);
            r = $urandom_range(0, 5); rom_mem[768 + i] = (r == 5) ? 3'd7 : 3'(r);
        end
        rom_mem[512 + 8'h11] = 3'd6; rom_mem[512 + 8'h44] = 3'd5;
        rom_mem[768 + 8'h80] = 3'd5; rom_mem[768 + 8'h81] = 3'd7; rom_mem[768 + 8'hFF] = 3'd7;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);

        // Basic load of stage 0.
        do_load(2'd0, -1, nd);
        check("s0_done_count", nd, 1);
        check("s0_player_x", player_x, 3);
        check("s0_player_y", player_y, 2);
        check("s0_box_count", box_count, 3);
        check("s0_error", error, 0);
        repeat (3) @(negedge clk);

        // Two players: last one (0x44) wins, map flagged invalid.
        do_load(2'd2, -1, nd);
        check("s2_error", error, 1);
        check("s2_player_x", player_x, 4);
        check("s2_player_y", player_y, 4);
        repeat (2) @(negedge clk);

        // Stage change plus stray request mid-copy: ignored.
        do_load(2'd0, 60, nd);
        check("mid_done_count", nd, 1);
        check("mid_player_x", player_x, 3);
        repeat (10) @(negedge clk);
        check("mid_no_restart", busy, 0);

        // Reset during write 100.
        stage = 2'd0; load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            if (ram_we && ram_addr == 8'd100) found = 1'b1;
            else @(negedge clk);
        end
        check("reach_write100", found, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_ram_we", ram_we, 0);
        check("abort_busy", busy, 0);
        check("abort_rom_addr", rom_addr, 0);
        check("abort_box", box_count, 0);
        @(posedge clk); #2 rst = 1'b0;
        nd = 0;
        repeat (20) begin @(negedge clk); if (done) nd++; end
        check("abort_no_done", nd, 0);

        // No player at all.
        do_load(2'd1, -1, nd);
        check("s1_error", error, 1);

        // Reserved cells, then a reload requested in the done cycle.
        do_load(2'd3, -1, nd);
        check("s3_error", error, 0);
        check("s3_player_x", player_x, 0);
        check("s3_player_y", player_y, 8);
        do_load(2'd0, -1, nd);
        check("reload_done_count", nd, 1);
        check("reload_player_x", player_x, 3);
        check("reload_box_count", box_count, 3);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/game_stage_loader.md
Name: game_stage_loader

Overview:
Sits directly downstream of the stage counter. It consumes the current stage index and copies that stage's level map from the level ROM into the playfield map RAM, one cell per cycle. While copying, it extracts the player start position and the count of boxes that are not on a goal. The game FSM then uses these values to start play.

Parameters:
STAGE_BITS, 2, width of stage index (matches stage counter q width)
COL_BITS, 4, log2 of grid columns (16 columns)
ROW_BITS, 4, log2 of grid rows (16 rows)
CELL_BITS, 3, width of one map cell code

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
stage  in  STAGE_BITS  stage index from the stage counter
load_req  in  1  single-cycle request to load the map for `stage`
rom_addr  out  STAGE_BITS+COL_BITS+ROW_BITS  level ROM address = {stage_latched, row, col}
rom_data  in  CELL_BITS  ROM read data, valid 1 cycle after rom_addr
ram_we  out  1  map RAM write enable
ram_addr  out  COL_BITS+ROW_BITS  map RAM address = {row, col}
ram_wdata  out  CELL_BITS  map RAM write data
busy  out  1  load in progress
done  out  1  one-cycle pulse, load complete
player_x  out  COL_BITS  player start column
player_y  out  ROW_BITS  player start row
box_count  out  COL_BITS+ROW_BITS+1  boxes not on a goal
error  out  1  map invalid: player cell count is not exactly 1

Behaviour:
- Cell codes: 0 floor, 1 wall, 2 goal, 3 box, 4 box_on_goal, 5 player, 6 player_on_goal, 7 reserved.
  - Code 7 is written to RAM as 0 (floor).
  - Code 7 does not set error.
- States: IDLE, PRIME, COPY, DONE.
- Reset (async): state IDLE; all outputs 0, including rom_addr, ram_*, busy, done, player_x/y, box_count and error.
- IDLE or DONE with load_req=1:
  - latch stage into stage_latched;
  - clear cell index, running player count and running box count;
  - go to PRIME. busy=1 from the next cycle.
- PRIME: rom_addr = {stage_latched, 0}; go to COPY.
- COPY, ROM pipeline of 1 cycle:
  - Each cycle, rom_addr advances to the next cell.
  - ram_we=1, ram_addr = previous cell index, ram_wdata = mapped rom_data.
  - Exactly 256 consecutive writes, cells 0..255 in order.
  - After the write of cell 255, go to DONE.
- Timing: if load_req is sampled at edge k, the first ram_we is in the cycle after edge k+1, and done pulses in the cycle after edge k+257.
- DONE (one cycle): done=1, busy=0, ram_we=0. player_x/y, box_count and error are updated this cycle from the running values; they hold until the next DONE or reset.
- Player position: set to the index of the last player or player_on_goal cell written.
- Player count: a running 2-bit count, saturating at 2. error=1 if the count is 0 or 2 at DONE.
- box_count counts code-3 cells only. The maximum is 256, which fits the 9-bit width.
- load_req while in PRIME or COPY: ignored, no queuing.
- load_req in the DONE cycle: accepted; a new load begins, with busy high in the following cycle.
- stage changing during a load: ignored; stage_latched is used throughout.
- rst asserted mid-load: abort immediately. ram_we and busy drop asynchronously and no done is issued. RAM contents are then partial, and the game FSM must re-request a load.

Decomposition:
- Shared package game_pkg holds:
  - cell code constants CELL_FLOOR..CELL_RSVD;
  - GRID_COL_BITS and GRID_ROW_BITS;
  - STAGE_BITS;
  - the loader state enum.
- One sub-module, loader_cell_stats, holds the running player count, player index latch and box counter.
  - Inputs: clear, write-valid, cell code, cell index.
  - Keeps the main FSM/address logic separate from the statistics logic.

Test Plan:
- ROM stage 0 has a wall border, player at cell 0x23 and 3 boxes; pulse load_req with stage=0 -> 256 writes matching ROM, then done, player_x=3, player_y=2, box_count=3, error=0.
- stage=2 with load_req -> rom_addr sweeps 0x200..0x2FF; first ram_we exactly 2 cycles after the load_req edge; done at +258 cycles.
- Change stage 0→1 mid-load, and pulse load_req during COPY -> addresses stay in stage 0, exactly one done, no restart.
- Assert rst at write 100 -> ram_we/busy drop immediately, all outputs 0, no done; a later load_req performs a full reload.
- Map with no player, then a map with two players (0x11, 0x44) -> error=1 in both cases; in the second, player_x=4, player_y=4.
- Pulse load_req in the done cycle; also load a map with code-7 cells -> second load starts next cycle with 256 writes; code-7 cells written as 0, error unaffected.
